// File: rtl/led_pkg.sv
// Shared types and helpers for the LED bank arbiter.
// Holds the FSM state encoding, requester indices and the small
// selection functions used by led_arbiter.
package led_pkg;

    localparam int unsigned NUM_REQ = 3;
    localparam int unsigned LED_W   = 8;
    localparam int unsigned IDX_W   = 2;

    localparam logic [IDX_W-1:0] REQ_BOOT = 2'd0;
    localparam logic [IDX_W-1:0] REQ_CPU  = 2'd1;
    localparam logic [IDX_W-1:0] REQ_ACT  = 2'd2;

    typedef enum logic [1:0] {
        LED_IDLE = 2'd0,
        LED_HOLD = 2'd1,
        LED_OPEN = 2'd2,
        LED_GAP  = 2'd3
    } led_state_t;

    // Highest-priority pending requester; caller guarantees r != 0.
    function automatic logic [IDX_W-1:0] prio_idx(input logic [NUM_REQ-1:0] r);
        logic [IDX_W-1:0] idx;
        if (r[REQ_BOOT])     idx = REQ_BOOT;
        else if (r[REQ_CPU]) idx = REQ_CPU;
        else                 idx = REQ_ACT;
        return idx;
    endfunction

    function automatic logic [NUM_REQ-1:0] idx_to_oh(input logic [IDX_W-1:0] idx);
        return NUM_REQ'(1) << idx;
    endfunction

    // First pending requester cyclically after owner (owner itself last).
    // The request vector is doubled so a window starting at owner+1 can be
    // priority-picked, then the window offset is added back modulo 3.
    function automatic logic [IDX_W-1:0] rot_idx(input logic [IDX_W-1:0] owner,
                                                 input logic [NUM_REQ-1:0] r);
        logic [2*NUM_REQ-1:0] dbl;
        logic [2:0]           base;
        logic [NUM_REQ-1:0]   win;
        logic [IDX_W-1:0]     k;
        logic [2:0]           sum;
        dbl  = {r, r};
        base = {1'b0, owner} + 3'd1;
        win  = dbl[base +: NUM_REQ];
        k    = prio_idx(win);
        sum  = base + {1'b0, k};
        return (sum >= 3'd3) ? IDX_W'(sum - 3'd3) : sum[IDX_W-1:0];
    endfunction

    function automatic logic [LED_W-1:0] sel_pat(input logic [IDX_W-1:0] idx,
                                                 input logic [LED_W-1:0] p0,
                                                 input logic [LED_W-1:0] p1,
                                                 input logic [LED_W-1:0] p2);
        logic [LED_W-1:0] p;
        case (idx)
            REQ_CPU: p = p1;
            REQ_ACT: p = p2;
            default: p = p0;
        endcase
        return p;
    endfunction

endpackage

// File: rtl/led_tick_gen.sv
// Hold-tick prescaler for the LED arbiter.
// Ports:
//   clock, reset : system clock, async active-high reset
//   restart      : synchronous restart of the count at a grant edge
//   tick         : registered one-cycle pulse, TICK_DIV clocks after restart
//   tick_c       : combinational "tick happens at this edge" strobe
module led_tick_gen #(
    parameter int unsigned TICK_DIV = 500_000
) (
    input  logic clock,
    input  logic reset,
    input  logic restart,
    output logic tick,
    output logic tick_c
);

    localparam int unsigned CNT_W = $clog2(TICK_DIV);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TICK_DIV - 1);

    logic [CNT_W-1:0] cnt;

    assign tick_c = (cnt == CNT_LAST);

    // Restart wins over wrap so a grant edge always starts a fresh period.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            cnt  <= '0;
            tick <= 1'b0;
        end else if (restart) begin
            cnt  <= '0;
            tick <= 1'b0;
        end else if (tick_c) begin
            cnt  <= '0;
            tick <= 1'b1;
        end else begin
            cnt  <= cnt + CNT_W'(1);
            tick <= 1'b0;
        end
    end

endmodule

// File: rtl/led_arbiter.sv
// Shares the 8-LED bank between boot animation (0), CPU register (1) and
// bus-activity indicator (2) with fixed priority, a minimum hold time,
// fair rotation of overstaying owners and a one-cycle handover gap.
// Ports:
//   clock, reset           : system clock, async active-high reset
//   req[2:0]               : per-requester request
//   pattern0/1/2[7:0]      : per-requester LED pattern
//   grant[2:0]             : registered one-hot owner, zero when idle/gap
//   leds[7:0]              : registered LED drive
//   tick                   : registered hold-tick pulse (debug)
module led_arbiter
    import led_pkg::*;
#(
    parameter int unsigned TICK_DIV = 500_000,
    parameter int unsigned MIN_HOLD = 2,
    parameter int unsigned MAX_HOLD = 40
) (
    input  logic               clock,
    input  logic               reset,
    input  logic [NUM_REQ-1:0] req,
    input  logic [LED_W-1:0]   pattern0,
    input  logic [LED_W-1:0]   pattern1,
    input  logic [LED_W-1:0]   pattern2,
    output logic [NUM_REQ-1:0] grant,
    output logic [LED_W-1:0]   leds,
    output logic               tick
);

    // Tenure must also reach MIN_HOLD when rotation is disabled.
    localparam int unsigned TEN_MAX = (MAX_HOLD > MIN_HOLD) ? MAX_HOLD : MIN_HOLD;
    localparam int unsigned TEN_W   = $clog2(TEN_MAX + 1);
    localparam logic [TEN_W-1:0] TEN_SAT  = TEN_W'(TEN_MAX);
    localparam logic [TEN_W-1:0] MIN_LAST = TEN_W'(MIN_HOLD - 1);
    localparam logic [TEN_W-1:0] MAX_L    = TEN_W'(MAX_HOLD);
    localparam bit               ROT_EN   = (MAX_HOLD != 0);

    led_state_t         state, state_nxt;
    logic [IDX_W-1:0]   owner_q, owner_nxt;
    logic               rotate_q, rotate_nxt;
    logic [TEN_W-1:0]   tenure_q;
    logic [NUM_REQ-1:0] grant_nxt;
    logic [LED_W-1:0]   leds_nxt;
    logic               restart_c;
    logic               tick_c;

    logic [NUM_REQ-1:0] own_oh;
    logic [LED_W-1:0]   own_pat;
    logic               owner_req;
    logic               higher_req;
    logic               other_req;
    logic               ten_full;
    logic [IDX_W-1:0]   pick;
    logic [LED_W-1:0]   pick_pat;

    led_tick_gen #(.TICK_DIV(TICK_DIV)) u_tick (
        .clock   (clock),
        .reset   (reset),
        .restart (restart_c),
        .tick    (tick),
        .tick_c  (tick_c)
    );

    // Owner-relative views of the request vector.
    assign own_oh     = idx_to_oh(owner_q);
    assign own_pat    = sel_pat(owner_q, pattern0, pattern1, pattern2);
    assign owner_req  = |(req & own_oh);
    assign higher_req = |(req & (own_oh - NUM_REQ'(1)));
    assign other_req  = |(req & ~own_oh);
    assign ten_full   = (tenure_q == MAX_L);

    // Next owner: cyclic successor after a rotation, otherwise priority.
    assign pick     = (state == LED_GAP && rotate_q) ? rot_idx(owner_q, req) : prio_idx(req);
    assign pick_pat = sel_pat(pick, pattern0, pattern1, pattern2);

    // Next-state and output decode.
    always_comb begin
        state_nxt  = state;
        owner_nxt  = owner_q;
        rotate_nxt = rotate_q;
        grant_nxt  = '0;
        leds_nxt   = leds;
        restart_c  = 1'b0;
        case (state)
            LED_IDLE: begin
                leds_nxt = '0;
                if (|req) begin
                    owner_nxt = pick;
                    grant_nxt = idx_to_oh(pick);
                    leds_nxt  = pick_pat;
                    restart_c = 1'b1;
                    state_nxt = LED_HOLD;
                end
            end
            LED_HOLD: begin
                grant_nxt = own_oh;
                if (owner_req) leds_nxt = own_pat;
                if (tick_c && tenure_q == MIN_LAST) state_nxt = LED_OPEN;
            end
            LED_OPEN: begin
                if (!owner_req || higher_req) begin
                    rotate_nxt = 1'b0;
                    state_nxt  = LED_GAP;
                end else if (ROT_EN && ten_full && other_req) begin
                    rotate_nxt = 1'b1;
                    state_nxt  = LED_GAP;
                end else begin
                    grant_nxt = own_oh;
                    leds_nxt  = own_pat;
                end
            end
            LED_GAP: begin
                if (|req) begin
                    owner_nxt = pick;
                    grant_nxt = idx_to_oh(pick);
                    leds_nxt  = pick_pat;
                    restart_c = 1'b1;
                    state_nxt = LED_HOLD;
                end else begin
                    leds_nxt  = '0;
                    state_nxt = LED_IDLE;
                end
            end
            default: state_nxt = LED_IDLE;
        endcase
    end

    // State, owner and output registers.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state    <= LED_IDLE;
            owner_q  <= REQ_BOOT;
            rotate_q <= 1'b0;
            grant    <= '0;
            leds     <= '0;
        end else begin
            state    <= state_nxt;
            owner_q  <= owner_nxt;
            rotate_q <= rotate_nxt;
            grant    <= grant_nxt;
            leds     <= leds_nxt;
        end
    end

    // Tenure in ticks since the grant edge, saturating.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            tenure_q <= '0;
        end else if (restart_c) begin
            tenure_q <= '0;
        end else if (tick_c && tenure_q != TEN_SAT) begin
            tenure_q <= tenure_q + TEN_W'(1);
        end
    end

endmodule
